// File: rtl/plasma_mem_responder.sv
// ----------------------------------------------------------------------------
// plasma_mem_responder
//
// Target side of the Plasma CPU memory bus. Accepts a CPU access selected by
// the bus decoder, forwards it to a slower downstream memory controller over
// a req/ack handshake and stalls the CPU with O_mem_pause until the downstream
// completes. A request that sees no ack within TIMEOUT cycles is aborted. The
// sticky O_timeout flag is set, and reads return ERR_WORD.
//
// Parameters:
//   ADDR_W   downstream word-address width (O_addr = CPU word address LSBs)
//   TIMEOUT  REQ cycles without ack before abort, 1..255 (8-bit counter)
//   ERR_WORD read data returned on an aborted read
//
// Ports:
//   I_clk, I_rst_n         clock, asynchronous active-low reset
//   I_enable               bus decoder select for this block
//   I_mem_address[29:0]    CPU word address (byte address bits [31:2])
//   I_mem_byte_we[3:0]     byte write enables, 0 = read
//   I_mem_data_write[31:0] CPU write data
//   O_mem_data_read[31:0]  read data to CPU, held until the next read
//   O_mem_pause            CPU stall (combinational)
//   O_req, O_we, O_addr, O_be, O_wdata   downstream request fields
//   I_ack, I_rdata         downstream completion pulse and read data
//   O_timeout              sticky abort flag, cleared only by reset
//
// Optional build macro: PLASMA_RESP_WRITE_POST_EN
//   When defined, a write seen in IDLE is posted. The CPU is not stalled for
//   it, and any access arriving before the FSM is back in IDLE is stalled
//   until the posted write has drained.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for I_enable; latches the access and raises O_req
// REQ   | O_req held with stable fields until I_ack or timeout
// DONE  | one-cycle completion; pause released for non-posted access
// ----------------------------------------------------------------------------
module plasma_mem_responder #(
    parameter int unsigned ADDR_W   = 22,
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              I_enable,
    input  logic [29:0]       I_mem_address,
    input  logic [3:0]        I_mem_byte_we,
    input  logic [31:0]       I_mem_data_write,
    output logic [31:0]       O_mem_data_read,
    output logic              O_mem_pause,
    output logic              O_req,
    output logic              O_we,
    output logic [ADDR_W-1:0] O_addr,
    output logic [3:0]        O_be,
    output logic [31:0]       O_wdata,
    input  logic              I_ack,
    input  logic [31:0]       I_rdata,
    output logic              O_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                timeout_q, timeout_d;

    logic                is_wr;
    logic [7:0]          cnt_inc;
    logic                timeout_hit;

    assign is_wr       = |I_mem_byte_we;
    assign cnt_inc     = cnt_q + 8'd1;
    // The cycle in which the counter would reach TIMEOUT is the last one
    // the request may wait; an ack in that same cycle still wins.
    assign timeout_hit = (cnt_inc == TIMEOUT_C);

`ifdef PLASMA_RESP_WRITE_POST_EN
    // Marks the in-flight transaction as a posted write, so the CPU stays
    // stalled through its DONE cycle instead of being released.
    logic posted_q, posted_d;
`endif

    generate
        if (ADDR_W < 30) begin : g_addr_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^I_mem_address[29:ADDR_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            timeout_q <= 1'b0;
`ifdef PLASMA_RESP_WRITE_POST_EN
            posted_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
`ifdef PLASMA_RESP_WRITE_POST_EN
            posted_q  <= posted_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
`ifdef PLASMA_RESP_WRITE_POST_EN
        posted_d  = posted_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (I_enable) begin
                    req_d   = 1'b1;
                    we_d    = is_wr;
                    addr_d  = I_mem_address[ADDR_W-1:0];
                    be_d    = is_wr ? I_mem_byte_we : 4'hF;
                    wdata_d = I_mem_data_write;
                    cnt_d   = 8'd0;
                    state_d = ST_REQ;
`ifdef PLASMA_RESP_WRITE_POST_EN
                    posted_d = is_wr;
`endif
                end
            end

            ST_REQ: begin
                if (I_ack) begin
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = I_rdata;
                    end
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    cnt_d     = cnt_inc;
                    if (!we_q) begin
                        rdata_d = ERR_WORD;
                    end
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end

            default: begin
                req_d   = 1'b0;
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        O_mem_pause = 1'b0;
`ifdef PLASMA_RESP_WRITE_POST_EN
        case (state_q)
            ST_IDLE: O_mem_pause = I_enable & ~is_wr;
            ST_REQ:  O_mem_pause = I_enable;
            ST_DONE: O_mem_pause = I_enable & posted_q;
            default: O_mem_pause = I_enable;
        endcase
`else
        O_mem_pause = I_enable & (state_q != ST_DONE);
`endif
    end

    assign O_req           = req_q;
    assign O_we            = we_q;
    assign O_addr          = addr_q;
    assign O_be            = be_q;
    assign O_wdata         = wdata_q;
    assign O_mem_data_read = rdata_q;
    assign O_timeout       = timeout_q;

endmodule

// File: tb/tb_plasma_mem_responder.sv
module tb_plasma_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [29:0] addr;
    logic [3:0]  bwe;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic        pause;
    logic        req;
    logic        we;
    logic [21:0] oaddr;
    logic [3:0]  be;
    logic [31:0] owdata;
    logic        ack;
    logic [31:0] irdata;
    logic        tmo;

    int n_cmp  = 0;
    int n_fail = 0;

    plasma_mem_responder #(
        .ADDR_W  (22),
        .TIMEOUT (4),
        .ERR_WORD(32'hDEADBEEF)
    ) dut (
        .I_clk           (clk),
        .I_rst_n         (rst_n),
        .I_enable        (en),
        .I_mem_address   (addr),
        .I_mem_byte_we   (bwe),
        .I_mem_data_write(wdata),
        .O_mem_data_read (rd),
        .O_mem_pause     (pause),
        .O_req           (req),
        .O_we            (we),
        .O_addr          (oaddr),
        .O_be            (be),
        .O_wdata         (owdata),
        .I_ack           (ack),
        .I_rdata         (irdata),
        .O_timeout       (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; addr = '0; bwe = 4'h0; wdata = '0;
        ack = 1'b0; irdata = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (req !== 1'b0)   begin n_fail++; $display("FAIL rst_req got %b want 0", req); end
        n_cmp++; if (we !== 1'b0)    begin n_fail++; $display("FAIL rst_we got %b want 0", we); end
        n_cmp++; if (oaddr !== 22'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", oaddr); end
        n_cmp++; if (be !== 4'h0)    begin n_fail++; $display("FAIL rst_be got %h want 0", be); end
        n_cmp++; if (owdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata got %h want 0", owdata); end
        n_cmp++; if (rd !== 32'h0)   begin n_fail++; $display("FAIL rst_rdata got %h want 0", rd); end
        n_cmp++; if (tmo !== 1'b0)   begin n_fail++; $display("FAIL rst_timeout got %b want 0", tmo); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL rst_pause got %b want 0", pause); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int req_cycles = 0;
        en = 1'b1; addr = 30'h0000_0100; bwe = 4'h0; wdata = 32'h0;
        #1;
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL rd_pause_idle got %b want 1", pause); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (req === 1'b1) req_cycles++;
            n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL rd_pause_req[%0d] got %b want 1", i, pause); end
            n_cmp++; if (oaddr !== 22'h100) begin n_fail++; $display("FAIL rd_addr[%0d] got %h want 100", i, oaddr); end
            n_cmp++; if (be !== 4'hF) begin n_fail++; $display("FAIL rd_be[%0d] got %h want f", i, be); end
            n_cmp++; if (we !== 1'b0) begin n_fail++; $display("FAIL rd_we[%0d] got %b want 0", i, we); end
            if (i == 2) begin ack = 1'b1; irdata = 32'h1234_5678; end
        end
        @(negedge clk);
        ack = 1'b0; irdata = 32'h0;
        if (req === 1'b1) req_cycles++;
        n_cmp++; if (req_cycles !== 3) begin n_fail++; $display("FAIL rd_req_cycles got %0d want 3", req_cycles); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL rd_pause_done got %b want 0", pause); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_data got %h want 12345678", rd); end
        en = 1'b0;
        @(negedge clk);
    endtask

`ifndef PLASMA_RESP_WRITE_POST_EN
    task automatic test_write();
        en = 1'b1; addr = 30'h0000_0200; bwe = 4'b0011; wdata = 32'hAABB_CCDD;
        #1;
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL wr_pause_idle got %b want 1", pause); end
        @(negedge clk);
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL wr_req got %b want 1", req); end
        n_cmp++; if (we !== 1'b1) begin n_fail++; $display("FAIL wr_we got %b want 1", we); end
        n_cmp++; if (be !== 4'b0011) begin n_fail++; $display("FAIL wr_be got %h want 3", be); end
        n_cmp++; if (owdata !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL wr_wdata got %h want aabbccdd", owdata); end
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL wr_pause_req got %b want 1", pause); end
        ack = 1'b1; irdata = 32'h5555_5555;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL wr_req_done got %b want 0", req); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL wr_pause_done got %b want 0", pause); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rdata_kept got %h want 12345678", rd); end
        en = 1'b0; bwe = 4'h0;
        @(negedge clk);
    endtask
`endif

    task automatic test_ack_outside_req();
        ack = 1'b1; irdata = 32'h9999_9999;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req got %b want 0", req); end
        n_cmp++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL stray_ack_rdata got %h want 12345678", rd); end
    endtask

    task automatic test_enable_drop();
        en = 1'b1; addr = 30'h0000_0050; bwe = 4'h0;
        @(negedge clk);
        en = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL drop_req got %b want 1", req); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL drop_pause got %b want 0", pause); end
        @(negedge clk);
        ack = 1'b1; irdata = 32'h0000_0077;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL drop_req_done got %b want 0", req); end
        n_cmp++; if (rd !== 32'h0000_0077) begin n_fail++; $display("FAIL drop_rdata got %h want 77", rd); end
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit();
        en = 1'b1; addr = 30'h0000_002A; bwe = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL lim_req[%0d] got %b want 1", i, req); end
        end
        ack = 1'b1; irdata = 32'hCAFE_F00D;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL lim_req_done got %b want 0", req); end
        n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL lim_timeout got %b want 0", tmo); end
        n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL lim_rdata got %h want cafef00d", rd); end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        en = 1'b1; addr = 30'h0000_003C; bwe = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL to_req[%0d] got %b want 1", i, req); end
            n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL to_early[%0d] got %b want 0", i, tmo); end
        end
        @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL to_req_drop got %b want 0", req); end
        n_cmp++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL to_flag got %b want 1", tmo); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata got %h want deadbeef", rd); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL to_pause_done got %b want 0", pause); end
        en = 1'b0;
        @(negedge clk);
        en = 1'b1; addr = 30'h0000_0044;
        @(negedge clk);
        n_cmp++; if (oaddr !== 22'h44) begin n_fail++; $display("FAIL to_next_addr got %h want 44", oaddr); end
        ack = 1'b1; irdata = 32'h55AA_55AA;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (rd !== 32'h55AA_55AA) begin n_fail++; $display("FAIL to_next_rdata got %h want 55aa55aa", rd); end
        n_cmp++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL to_sticky got %b want 1", tmo); end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dup = 0;
        en = 1'b1; addr = 30'h0000_0010; bwe = 4'h0;
        @(negedge clk);
        if (req === 1'b1 && oaddr === 22'h10) dup++;
        @(negedge clk);
        if (req === 1'b1 && oaddr === 22'h10) dup++;
        ack = 1'b1; irdata = 32'h0000_1010;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (rd !== 32'h0000_1010) begin n_fail++; $display("FAIL b2b_rdata0 got %h want 1010", rd); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL b2b_pause0 got %b want 0", pause); end
        addr = 30'h0000_0014;
        @(negedge clk);
        if (req === 1'b1 && oaddr === 22'h10) dup++;
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL b2b_pause_idle got %b want 1", pause); end
        @(negedge clk);
        n_cmp++; if (dup !== 2) begin n_fail++; $display("FAIL b2b_dup got %0d want 2", dup); end
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL b2b_req1 got %b want 1", req); end
        n_cmp++; if (oaddr !== 22'h14) begin n_fail++; $display("FAIL b2b_addr1 got %h want 14", oaddr); end
        @(negedge clk);
        ack = 1'b1; irdata = 32'h0000_1414;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (rd !== 32'h0000_1414) begin n_fail++; $display("FAIL b2b_rdata1 got %h want 1414", rd); end
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        en = 1'b1; addr = 30'h0000_0060; bwe = 4'h0;
        @(negedge clk);
        n_cmp++; if (req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_before got %b want 1", req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0) begin n_fail++; $display("FAIL rmid_req got %b want 0", req); end
        n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rmid_timeout got %b want 0", tmo); end
        n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rmid_rdata got %h want 0", rd); end
        en = 1'b0;
        #1;
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL rmid_pause got %b want 0", pause); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1; addr = 30'h0000_0080;
        @(negedge clk);
        n_cmp++; if (oaddr !== 22'h80) begin n_fail++; $display("FAIL rmid_fresh_addr got %h want 80", oaddr); end
        ack = 1'b1; irdata = 32'h0BAD_F00D;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL rmid_fresh_rdata got %h want 0badf00d", rd); end
        en = 1'b0;
        @(negedge clk);
    endtask

`ifdef PLASMA_RESP_WRITE_POST_EN
    task automatic test_write_post();
        en = 1'b1; addr = 30'h0000_0300; bwe = 4'hF; wdata = 32'h1122_3344;
        #1;
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL post_wr_pause got %b want 0", pause); end
        @(negedge clk);
        addr = 30'h0000_0020; bwe = 4'h0;
        #1;
        n_cmp++; if (req !== 1'b1 || we !== 1'b1) begin n_fail++; $display("FAIL post_wr_req got %b/%b want 1/1", req, we); end
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL post_rd_pause0 got %b want 1", pause); end
        repeat (2) @(negedge clk);
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL post_rd_pause1 got %b want 1", pause); end
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL post_rd_pause_done got %b want 1", pause); end
        @(negedge clk);
        n_cmp++; if (pause !== 1'b1) begin n_fail++; $display("FAIL post_rd_pause_idle got %b want 1", pause); end
        @(negedge clk);
        n_cmp++; if (req !== 1'b1 || oaddr !== 22'h20 || we !== 1'b0) begin n_fail++; $display("FAIL post_rd_req got %b/%h/%b want 1/20/0", req, oaddr, we); end
        ack = 1'b1; irdata = 32'h0000_2020;
        @(negedge clk);
        ack = 1'b0;
        n_cmp++; if (rd !== 32'h0000_2020) begin n_fail++; $display("FAIL post_rd_data got %h want 2020", rd); end
        n_cmp++; if (pause !== 1'b0) begin n_fail++; $display("FAIL post_rd_pause_end got %b want 0", pause); end
        en = 1'b0;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
`ifndef PLASMA_RESP_WRITE_POST_EN
        test_write();
`endif
        test_ack_outside_req();
        test_enable_drop();
        test_ack_at_limit();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
`ifdef PLASMA_RESP_WRITE_POST_EN
        test_write_post();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
